// File: rtl/regfile_multiport_sb.sv
// Multi-port RV32 register file with a per-register pending-write counter (scoreboard).
// Optional feature macro: RF_WR_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_multiport_sb #(
    parameter int DWIDTH = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int CNTW   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rd_addr_i,
    output logic [NRD*DWIDTH-1:0] rd_data_o,
    output logic [NRD-1:0]        rd_ready_o,
    input  logic [NWR-1:0]        wr_en_i,
    input  logic [NWR*AW-1:0]     wr_addr_i,
    input  logic [NWR*DWIDTH-1:0] wr_data_i,
    input  logic                  iss_en_i,
    input  logic [AW-1:0]         iss_rd_i,
    output logic                  iss_ready_o,
    output logic                  sb_err_o
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [DWIDTH-1:0] regs    [NREGS];
    logic [CNTW-1:0]   cnt     [NREGS];
    logic [CNTW-1:0]   cnt_nxt [NREGS];
    logic [NREGS-1:0]  wr_hit;
    logic [DWIDTH-1:0] wr_val  [NREGS];
    int                dec     [NREGS];
    logic [CNTW-1:0]   iss_cnt;
    logic              iss_wr;
    logic              err_set;
    logic              sb_err_q;

    // Per-register write decode; ascending port order makes the highest port win the data.
    // Register 0 and out-of-range addresses never match, so they are ignored for free.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            dec[r]    = 0;
            if (r != 0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en_i[w] && wr_addr_i[w*AW +: AW] == AW'(r)) begin
                        wr_hit[r] = 1'b1;
                        wr_val[r] = wr_data_i[w*DWIDTH +: DWIDTH];
                        dec[r]    = dec[r] + 1;
                    end
                end
            end
        end
    end

    // Issue is refused only when the destination is saturated and no write frees a slot now.
    always_comb begin
        iss_cnt = '0;
        iss_wr  = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (iss_rd_i == AW'(r)) begin
                iss_cnt = cnt[r];
                iss_wr  = wr_hit[r];
            end
        end
        iss_ready_o = !(iss_en_i && iss_cnt == CNT_MAX && !iss_wr);
    end

    always_comb begin
        int sum;
        err_set = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            sum = int'(cnt[r]) - dec[r];
            if (r != 0 && iss_en_i && iss_ready_o && iss_rd_i == AW'(r))
                sum = sum + 1;
            cnt_nxt[r] = (sum <= 0) ? '0 : CNTW'(sum);
            if (cnt[r] == '0 && dec[r] != 0)
                err_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wr_hit[r])
                    regs[r] <= wr_val[r];
                cnt[r] <= cnt_nxt[r];
            end
            if (err_set)
                sb_err_q <= 1'b1;
        end
    end

    assign sb_err_o = sb_err_q;

    // Unmatched addresses (x0, out of range) fall through to data 0, ready 1.
    always_comb begin
        rd_data_o  = '0;
        rd_ready_o = '1;
        for (int p = 0; p < NRD; p++) begin
            for (int r = 1; r < NREGS; r++) begin
                if (rd_addr_i[p*AW +: AW] == AW'(r)) begin
                    rd_data_o[p*DWIDTH +: DWIDTH] = regs[r];
                    rd_ready_o[p]                 = (cnt[r] == '0);
`ifdef RF_WR_BYPASS_EN
                    if (wr_hit[r]) begin
                        rd_data_o[p*DWIDTH +: DWIDTH] = wr_val[r];
                        rd_ready_o[p]                 = (int'(cnt[r]) <= dec[r]);
                    end
`endif
                end
            end
        end
    end

endmodule
